// File: rtl/a_res_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : a_res_sched_pkg
// Description : Shared constants and types for the A-register reservation
//               scheduler: A-bus source codes, timing constants, register
//               file geometry and the writeback timeline slot record.
// Revision    : 1.0 - initial release
// ============================================================================
package a_res_sched_pkg;

  // A register file geometry
  localparam int A_NUM_AREG  = 8;
  localparam int A_AW        = $clog2(A_NUM_AREG);

  // Result delay encoding
  localparam int A_MAX_DELAY = 15;
  localparam int DELAY_W     = 4;

  // Functional-unit source code width
  localparam int A_SRC_W     = 4;

  // A booking of this delay bypasses the timeline and loads the port directly
  localparam int WB_PORT_TIME  = 1;
  // Smallest delay that produces a result at all (0 means no result)
  localparam int MIN_BOOK_TIME = 1;

  // Functional-unit buses that can drive the A write port
  typedef enum logic [A_SRC_W-1:0] {
    ABUS_NONE = 4'd0,
    ABUS_IMM  = 4'd1,
    ABUS_ADD  = 4'd2,
    ABUS_MUL  = 4'd3,
    ABUS_POP  = 4'd4,
    ABUS_MEM  = 4'd5,
    ABUS_SREG = 4'd6
  } abus_e;

  // One writeback timeline entry
  typedef struct packed {
    logic                 valid;
    logic [A_AW-1:0]      addr;
    logic [A_SRC_W-1:0]   src;
  } a_slot_t;

  // Build a valid slot entry for a booking
  function automatic a_slot_t mk_slot(input logic [A_AW-1:0] addr,
                                      input logic [A_SRC_W-1:0] src);
    a_slot_t s;
    s.valid = 1'b1;
    s.addr  = addr;
    s.src   = src;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/a_res_sched_wb_timeline.sv
`default_nettype none
// ============================================================================
// Module      : a_wb_timeline
// Description : Writeback timeline. Slot n holds the result that will appear
//               on the A write port n cycles after the current cycle. Slots
//               shift down by one every clock; a booking of delay d lands in
//               slot d-1 after the shift so it reaches the port d cycles
//               after issue. Delay 1 bookings bypass the timeline (handled by
//               the scheduler). The top slot (d = MAX_DELAY) is always empty
//               in the current cycle, so it is not stored.
// Revision    : 1.0 - initial release
// ============================================================================
module a_wb_timeline
  import a_res_sched_pkg::*;
#(
  parameter int MAX_DELAY = A_MAX_DELAY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               book_en,
  input  logic [DELAY_W-1:0] book_delay,
  input  a_slot_t            book_slot,
  input  logic [DELAY_W-1:0] query_delay,
  output logic               query_occupied,
  output a_slot_t            head
);

  localparam int NSLOT = MAX_DELAY - 1;

  a_slot_t slot_q [1:NSLOT];
  a_slot_t slot_d [1:NSLOT];

  // Shift every slot down by one and drop the booking into its post-shift slot
  always_comb begin
    for (int n = 1; n < NSLOT; n++) begin
      slot_d[n] = slot_q[n+1];
    end
    slot_d[NSLOT] = '0;
    for (int n = 1; n <= NSLOT; n++) begin
      if (book_en && (int'(book_delay) == n + 1)) begin
        slot_d[n] = book_slot;
      end
    end
  end

  // Is the slot a delay-d booking would collide with already taken?
  always_comb begin
    query_occupied = 1'b0;
    for (int n = 1; n <= NSLOT; n++) begin
      if (int'(query_delay) == n) begin
        query_occupied = slot_q[n].valid;
      end
    end
  end

  // Timeline storage; reset discards every pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n <= NSLOT; n++) begin
        slot_q[n] <= '0;
      end
    end else begin
      for (int n = 1; n <= NSLOT; n++) begin
        slot_q[n] <= slot_d[n];
      end
    end
  end

  assign head = slot_q[1];

endmodule
`default_nettype wire

// File: rtl/a_res_sched.sv
`default_nettype none
// ============================================================================
// Module      : a_res_sched
// Description : A-register reservation scheduler. Books A-register results
//               into a writeback timeline, keeps per-register busy bits,
//               raises issue hold on RAW / WAW / write-port conflicts and
//               drives the single A register-file write port.
//               Optional build macro A_WB_BYPASS_EN: the register being
//               written this cycle is treated as free for hazard checks
//               (write-through register file).
// Revision    : 1.0 - initial release
// ============================================================================
module a_res_sched
  import a_res_sched_pkg::*;
#(
  parameter int NUM_AREG  = A_NUM_AREG,
  parameter int MAX_DELAY = A_MAX_DELAY,
  parameter int SRC_W     = A_SRC_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_issue,
  input  logic                        i_a_dest_en,
  input  logic [DELAY_W-1:0]          i_delay,
  input  logic [SRC_W-1:0]            i_src,
  input  logic [$clog2(NUM_AREG)-1:0] i_dest,
  input  logic                        i_rd_j_en,
  input  logic                        i_rd_k_en,
  input  logic [$clog2(NUM_AREG)-1:0] i_rd_j,
  input  logic [$clog2(NUM_AREG)-1:0] i_rd_k,
  output logic                        o_hold,
  output logic                        o_issue_ok,
  output logic                        o_a_wr_en,
  output logic [$clog2(NUM_AREG)-1:0] o_a_wr_addr,
  output logic [SRC_W-1:0]            o_a_wr_src,
  output logic [NUM_AREG-1:0]         o_a_busy
);

  logic [NUM_AREG-1:0] busy_q;
  logic [NUM_AREG-1:0] busy_d;
  logic [NUM_AREG-1:0] busy_eff;
  logic [NUM_AREG-1:0] set_mask;
  logic [NUM_AREG-1:0] clr_mask;
  logic                book_req;
  logic                book;
  logic                raw_hit;
  logic                waw_hit;
  logic                port_hit;
  logic                occupied;
  a_slot_t             new_slot;
  a_slot_t             head;
  a_slot_t             wr_q;
  a_slot_t             wr_d;

  assign new_slot = mk_slot(i_dest, i_src);

  // Busy view used by the hazard checks (write-through frees the written reg)
  always_comb begin
    busy_eff = busy_q;
`ifdef A_WB_BYPASS_EN
    if (wr_q.valid) begin
      busy_eff[wr_q.addr] = 1'b0;
    end
`endif
  end

  // Hazard detection and issue acceptance
  always_comb begin
    book_req = i_a_dest_en && (i_delay >= DELAY_W'(MIN_BOOK_TIME));
    raw_hit  = (i_rd_j_en && busy_eff[i_rd_j]) ||
               (i_rd_k_en && busy_eff[i_rd_k]);
    waw_hit  = book_req && busy_eff[i_dest];
    port_hit = book_req && occupied;
    o_hold     = i_issue && (raw_hit || waw_hit || port_hit);
    o_issue_ok = i_issue && !o_hold;
    book       = o_issue_ok && book_req;
  end

  a_wb_timeline #(
    .MAX_DELAY (MAX_DELAY)
  ) u_timeline (
    .clk            (clk),
    .rst_n          (rst_n),
    .book_en        (book),
    .book_delay     (i_delay),
    .book_slot      (new_slot),
    .query_delay    (i_delay),
    .query_occupied (occupied),
    .head           (head)
  );

  // Next write-port contents: a delay-1 booking goes straight to the port
  always_comb begin
    wr_d = head;
    if (book && (i_delay == DELAY_W'(WB_PORT_TIME))) begin
      wr_d = new_slot;
    end
  end

  // Busy update: a new booking wins over the clear of the register being written
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (book) begin
      set_mask[i_dest] = 1'b1;
    end
    if (wr_q.valid) begin
      clr_mask[wr_q.addr] = 1'b1;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Busy vector and write-port output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      wr_q   <= '0;
    end else begin
      busy_q <= busy_d;
      wr_q   <= wr_d;
    end
  end

  assign o_a_wr_en   = wr_q.valid;
  assign o_a_wr_addr = wr_q.addr;
  assign o_a_wr_src  = wr_q.src;
  assign o_a_busy    = busy_q;

endmodule
`default_nettype wire

// File: doc/a_res_sched.md
Name: a_res_sched

Overview:
- A-register reservation scheduler; sits directly downstream of the A-register result look-up table (delay/source/dest-enable per issuing instruction).
- Books each A-register result into a writeback timeline, tracks per-register busy bits, generates issue hold on RAW/WAW/write-port conflicts.
- Drives the single A register-file write port: when to write, which register, which functional-unit bus to select.

Parameters:
- NUM_AREG, 8, number of A registers (address width log2 = 3)
- MAX_DELAY, 15, largest encodable result delay (i_delay is 4 bits)
- SRC_W, 4, width of functional-unit source code

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_issue  in  1  instruction in CIP requests issue this cycle
- i_a_dest_en  in  1  instruction writes an A register
- i_delay  in  4  cycles from issue to result (0 = no result)
- i_src  in  SRC_W  result source bus code
- i_dest  in  3  destination A register (i field)
- i_rd_j_en, i_rd_k_en  in  1 each  instruction reads Aj / Ak
- i_rd_j, i_rd_k  in  3 each  read register addresses
- o_hold  out  1  combinational: issue blocked this cycle
- o_issue_ok  out  1  combinational: i_issue && !o_hold
- o_a_wr_en  out  1  registered: A write-port enable
- o_a_wr_addr  out  3  registered: A write address
- o_a_wr_src  out  SRC_W  registered: A write-data bus select
- o_a_busy  out  NUM_AREG  registered: per-register reservation bits

Behaviour:
- Reset (async, rst_n=0): all timeline slots invalid, o_a_busy=0, o_a_wr_en=0, o_a_wr_addr=0, o_a_wr_src=0. Reset mid-operation discards all pending results; no writeback after release.
- Timeline: slots 1..MAX_DELAY, each {valid, addr, src}. Every clock slot n takes slot n+1; slot MAX_DELAY refills invalid unless written by issue.
- Writeback register loads from slot 1 each clock: o_a_wr_en/addr/src reflect slot 1 contents of previous cycle.
- Booking: accepted issue at cycle T with i_a_dest_en=1, i_delay=d (d>=1) writes slot d (post-shift position) so o_a_wr_en=1 during exactly cycle T+d.
- i_delay=0 with i_a_dest_en=1: no booking, no busy set, no hold contribution from dest (defined as no-op).
- Busy: o_a_busy[dest] set from T+1 through T+d inclusive; cleared at T+d+1 unless re-booked.
- o_hold = i_issue && any of:
  - RAW: i_rd_j_en && o_a_busy[i_rd_j], or same for k.
  - WAW: i_a_dest_en && d>=1 && o_a_busy[i_dest].
  - Port conflict: i_a_dest_en && d>=1 && target slot already valid.
- Held instruction: no state change; it re-requests next cycle (CIP held upstream).
- Simultaneous writeback to r and issue reading r in the same cycle: busy still set -> hold (no bypass) unless optional feature compiled in.
- No issue while i_issue=0; i_dest/i_src ignored.
- Only one result per cycle on the port by construction; invariant: at most one valid slot per register.

Optional Feature:
- Macro A_WB_BYPASS_EN.
- With it: busy for register r excluded from RAW/WAW checks in the cycle o_a_wr_en=1 with o_a_wr_addr=r (register file is write-through); reader issues same cycle as writeback.
- Without it: busy honoured through the writeback cycle; reader issues at T+d+1 earliest.

Decomposition:
- Shared package/include: A-bus source codes (ABUS_*), timing defines (*_TIME), NUM_AREG, A address width.
- One sub-module: a_wb_timeline (shift-register of slots, booking port, slot-occupied query, slot-1 output); scheduler top holds busy vector, hazard logic, output register.

Test Plan:
- Issue dest=A3, delay=1, src=ABUS_IMM at T -> o_a_wr_en=1, addr=3, src=ABUS_IMM at T+1; o_a_busy[3]=1 only at T+1.
- Issue dest=A2 delay=5 at T, then at T+1 reader with i_rd_j=2 -> o_hold=1 T+1..T+5, o_issue_ok at T+6 (T+5 with A_WB_BYPASS_EN).
- Issue A1 delay=6 at T, then A4 delay=5 at T+1 -> port conflict, o_hold=1 at T+1; issue at T+2 accepted, writebacks at T+6 (A1) and T+7 (A4).
- Issue A5 delay=4, then A5 delay=2 next cycle -> WAW hold until busy clears; single write to A5 per booking, none overlapping.
- i_a_dest_en=1, i_delay=0 -> no hold, no busy, no writeback ever.
- Three results pending, assert rst_n=0 for 1 cycle -> all outputs 0 immediately, no o_a_wr_en after release.
